// File: rtl/frame_timer_bank.sv
// frame_timer_bank: bank of N_CH frame-tick counters driven by one
// asynchronous new_frame strobe.
//
// Ports:
//   clk         system clock, all state changes on its rising edge
//   reset       asynchronous active-low reset
//   new_frame   frame strobe, asynchronous; each rising edge is one tick
//   start       per-channel start/restart request (one cycle)
//   stop        per-channel abort request (one cycle)
//   pause       per-channel level, freezes a running channel
//   loop_mode   per-channel wrap (1) / one-shot (0), latched at start
//   limit       per-channel terminal count, channel i at [i*WIDTH +: WIDTH]
//   count       per-channel frame count, same packing as limit
//   running     per-channel, high while in RUN
//   done        per-channel sticky, high while in DONE
//   done_pulse  per-channel one-cycle pulse on each terminal-count event
module frame_timer_bank #(
    parameter int N_CH        = 4,
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    new_frame,
    input  logic [N_CH-1:0]         start,
    input  logic [N_CH-1:0]         stop,
    input  logic [N_CH-1:0]         pause,
    input  logic [N_CH-1:0]         loop_mode,
    input  logic [N_CH*WIDTH-1:0]   limit,
    output logic [N_CH*WIDTH-1:0]   count,
    output logic [N_CH-1:0]         running,
    output logic [N_CH-1:0]         done,
    output logic [N_CH-1:0]         done_pulse
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] vld_q;
    logic                   prev_q;
    logic                   blocked_q;
    logic                   tick_q;
    logic                   sync_last;
    logic                   vld_last;

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign vld_last  = vld_q[SYNC_STAGES-1];

    // vld_q marks when sync_last holds a real post-reset sample.
    // blocked_q stays set until such a sample is low, so a strobe
    // already high at reset release cannot produce a tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q    <= '0;
            vld_q     <= '0;
            prev_q    <= 1'b0;
            blocked_q <= 1'b1;
            tick_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], new_frame};
            vld_q  <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            prev_q <= sync_last;
            if (vld_last && !sync_last) begin
                blocked_q <= 1'b0;
            end
            tick_q <= !blocked_q && sync_last && !prev_q;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t           state_q;
        logic [WIDTH-1:0] cnt_q;
        logic [WIDTH-1:0] lim_q;
        logic             mode_q;
        logic             run_q;
        logic             done_q;
        logic             pulse_q;
        logic [WIDTH-1:0] nxt;
        logic [WIDTH-1:0] lim_in;

        assign lim_in = limit[i*WIDTH +: WIDTH];
        assign nxt    = cnt_q + WIDTH'(1);

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                lim_q   <= '0;
                mode_q  <= 1'b0;
                run_q   <= 1'b0;
                done_q  <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                pulse_q <= 1'b0;
                if (stop[i]) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    run_q   <= 1'b0;
                    done_q  <= 1'b0;
                end else if (start[i]) begin
                    lim_q  <= lim_in;
                    mode_q <= loop_mode[i];
                    cnt_q  <= '0;
                    if (lim_in == '0) begin
                        // zero limit terminates at once
                        state_q <= DONE;
                        run_q   <= 1'b0;
                        done_q  <= 1'b1;
                        pulse_q <= 1'b1;
                    end else begin
                        state_q <= RUN;
                        run_q   <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end else begin
                    unique case (state_q)
                        RUN: begin
                            if (pause[i]) begin
                                state_q <= PAUSE;
                                run_q   <= 1'b0;
                            end else if (tick_q) begin
                                if (nxt == lim_q) begin
                                    pulse_q <= 1'b1;
                                    if (mode_q) begin
                                        cnt_q <= '0;
                                    end else begin
                                        cnt_q   <= lim_q;
                                        state_q <= DONE;
                                        run_q   <= 1'b0;
                                        done_q  <= 1'b1;
                                    end
                                end else begin
                                    cnt_q <= nxt;
                                end
                            end
                        end
                        PAUSE: begin
                            if (!pause[i]) begin
                                state_q <= RUN;
                                run_q   <= 1'b1;
                            end
                        end
                        IDLE, DONE: begin
                            state_q <= state_q;
                        end
                        default: begin
                            state_q <= IDLE;
                            run_q   <= 1'b0;
                            done_q  <= 1'b0;
                        end
                    endcase
                end
            end
        end

        assign count[i*WIDTH +: WIDTH] = cnt_q;
        assign running[i]              = run_q;
        assign done[i]                 = done_q;
        assign done_pulse[i]           = pulse_q;
    end

endmodule

// File: tb/tb_frame_timer_bank.sv
// tb_frame_timer_bank: directed and randomized checks of frame_timer_bank
// against a cycle-level behavioural model of the channel rules.
module tb_frame_timer_bank;
    localparam int N = 4;
    localparam int W = 16;
    localparam int S = 2;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic           new_frame;
    logic [N-1:0]   start, stop, pause, loop_mode;
    logic [N*W-1:0] limit;
    logic [N*W-1:0] count;
    logic [N-1:0]   running, done, done_pulse;

    always #5 clk = ~clk;

    frame_timer_bank #(.N_CH(N), .WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk(clk), .reset(reset), .new_frame(new_frame),
        .start(start), .stop(stop), .pause(pause),
        .loop_mode(loop_mode), .limit(limit), .count(count),
        .running(running), .done(done), .done_pulse(done_pulse)
    );

    int tests = 0;
    int fails = 0;

    int m_st[N];
    int m_cnt[N];
    int m_lim[N];
    bit m_loop[N];
    bit m_pls[N];
    bit tick_sched[int];
    int edge_no = 0;
    bit nf_prev = 1'b1;
    int pc[N];

    function automatic void model_clear();
        for (int c = 0; c < N; c++) begin
            m_st[c] = M_IDLE; m_cnt[c] = 0; m_lim[c] = 0;
            m_loop[c] = 1'b0; m_pls[c] = 1'b0;
        end
        tick_sched.delete();
        nf_prev = 1'b1;
    endfunction

    function automatic logic [N*W-1:0] exp_count();
        logic [N*W-1:0] r;
        r = '0;
        for (int c = 0; c < N; c++) r[c*W +: W] = W'(m_cnt[c]);
        return r;
    endfunction

    function automatic logic [N-1:0] exp_bits(int kind);
        logic [N-1:0] r;
        r = '0;
        for (int c = 0; c < N; c++) begin
            if (kind == 0) r[c] = (m_st[c] == M_RUN);
            else if (kind == 1) r[c] = (m_st[c] == M_DONE);
            else r[c] = m_pls[c];
        end
        return r;
    endfunction

    function automatic int cnt_of(int c);
        return int'(count[c*W +: W]);
    endfunction

    function automatic void set_lim(int c, int v);
        limit[c*W +: W] = W'(v);
    endfunction

    // Advance one clock: update the model with the inputs now driven,
    // then let the DUT take the same edge.
    task automatic step();
        bit tk;
        tk = tick_sched.exists(edge_no);
        if (reset) begin
            if (new_frame && !nf_prev) tick_sched[edge_no + S + 1] = 1'b1;
            nf_prev = new_frame;
            for (int c = 0; c < N; c++) begin
                m_pls[c] = 1'b0;
                if (stop[c]) begin
                    m_st[c] = M_IDLE; m_cnt[c] = 0;
                end else if (start[c]) begin
                    m_lim[c] = int'(limit[c*W +: W]);
                    m_loop[c] = loop_mode[c];
                    m_cnt[c] = 0;
                    if (m_lim[c] == 0) begin
                        m_st[c] = M_DONE; m_pls[c] = 1'b1;
                    end else m_st[c] = M_RUN;
                end else if (m_st[c] == M_RUN && pause[c]) begin
                    m_st[c] = M_PAUSE;
                end else if (m_st[c] == M_PAUSE && !pause[c]) begin
                    m_st[c] = M_RUN;
                end else if (m_st[c] == M_RUN && tk) begin
                    if (m_cnt[c] + 1 == m_lim[c]) begin
                        m_pls[c] = 1'b1;
                        if (m_loop[c]) m_cnt[c] = 0;
                        else begin
                            m_cnt[c] = m_lim[c]; m_st[c] = M_DONE;
                        end
                    end else m_cnt[c] = m_cnt[c] + 1;
                end
            end
        end else model_clear();
        @(posedge clk);
        #1;
        edge_no++;
        start = '0;
        stop = '0;
        for (int c = 0; c < N; c++) pc[c] += int'(done_pulse[c]);
    endtask

    task automatic steps(int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // One full frame strobe; the tick lands inside this window.
    task automatic frame();
        for (int c = 0; c < N; c++) pc[c] = 0;
        new_frame = 1'b1;
        step();
        new_frame = 1'b0;
        steps(S + 2);
    endtask

    task automatic test_reset();
        reset = 1'b1; new_frame = 1'b0;
        start = '0; stop = '0; pause = '0; loop_mode = '0; limit = '0;
        #1;
        reset = 1'b0;
        #1;
        model_clear();
        tests++;
        if (count !== '0 || running !== '0 || done !== '0 || done_pulse !== '0) begin
            fails++;
            $display("FAIL reset_state: count=%h run=%b done=%b pulse=%b want 0",
                     count, running, done, done_pulse);
        end
        steps(2);
        reset = 1'b1;
        steps(4);
        tests++;
        if (count !== '0 || running !== '0 || done !== '0) begin
            fails++;
            $display("FAIL reset_release: count=%h run=%b done=%b want 0",
                     count, running, done);
        end
    endtask

    task automatic test_oneshot();
        int want[3] = '{1, 2, 3};
        set_lim(0, 3); loop_mode[0] = 1'b0; start[0] = 1'b1;
        step();
        set_lim(0, 1);
        tests++;
        if (running[0] !== 1'b1 || cnt_of(0) != 0) begin
            fails++;
            $display("FAIL oneshot_start: run=%b count=%0d want 1/0", running[0], cnt_of(0));
        end
        for (int k = 0; k < 3; k++) begin
            frame();
            tests++;
            if (cnt_of(0) != want[k]) begin
                fails++;
                $display("FAIL oneshot_count%0d: got %0d want %0d", k, cnt_of(0), want[k]);
            end
        end
        tests++;
        if (done[0] !== 1'b1 || running[0] !== 1'b0 || pc[0] != 1) begin
            fails++;
            $display("FAIL oneshot_done: done=%b run=%b pulses=%0d want 1/0/1",
                     done[0], running[0], pc[0]);
        end
        frame();
        frame();
        tests++;
        if (cnt_of(0) != 3 || pc[0] != 0 || done[0] !== 1'b1) begin
            fails++;
            $display("FAIL oneshot_hold: count=%0d pulses=%0d done=%b want 3/0/1",
                     cnt_of(0), pc[0], done[0]);
        end
    endtask

    task automatic test_loop();
        int want[5] = '{1, 0, 1, 0, 1};
        int wp[5] = '{0, 1, 0, 1, 0};
        set_lim(1, 2); loop_mode[1] = 1'b1; start[1] = 1'b1;
        step();
        loop_mode[1] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            frame();
            tests++;
            if (cnt_of(1) != want[k] || pc[1] != wp[k] || done[1] !== 1'b0) begin
                fails++;
                $display("FAIL loop_tick%0d: count=%0d pulses=%0d done=%b want %0d/%0d/0",
                         k, cnt_of(1), pc[1], done[1], want[k], wp[k]);
            end
        end
    endtask

    task automatic test_pause();
        set_lim(0, 20); start[0] = 1'b1;
        step();
        for (int k = 0; k < 5; k++) frame();
        tests++;
        if (cnt_of(0) != 5) begin
            fails++;
            $display("FAIL pause_pre: count=%0d want 5", cnt_of(0));
        end
        pause[0] = 1'b1;
        step();
        for (int k = 0; k < 3; k++) frame();
        tests++;
        if (cnt_of(0) != 5 || running[0] !== 1'b0) begin
            fails++;
            $display("FAIL pause_hold: count=%0d run=%b want 5/0", cnt_of(0), running[0]);
        end
        pause[0] = 1'b0;
        step();
        frame();
        tests++;
        if (cnt_of(0) != 6 || running[0] !== 1'b1) begin
            fails++;
            $display("FAIL pause_resume: count=%0d run=%b want 6/1", cnt_of(0), running[0]);
        end
    endtask

    task automatic test_start_stop_zero();
        set_lim(2, 9); start[2] = 1'b1;
        step();
        frame();
        start[2] = 1'b1; stop[2] = 1'b1;
        step();
        tests++;
        if (running[2] !== 1'b0 || cnt_of(2) != 0 || done[2] !== 1'b0) begin
            fails++;
            $display("FAIL start_stop: run=%b count=%0d done=%b want 0/0/0",
                     running[2], cnt_of(2), done[2]);
        end
        set_lim(2, 0); loop_mode[2] = 1'b1; start[2] = 1'b1;
        step();
        tests++;
        if (done[2] !== 1'b1 || done_pulse[2] !== 1'b1 || cnt_of(2) != 0) begin
            fails++;
            $display("FAIL zero_limit: done=%b pulse=%b count=%0d want 1/1/0",
                     done[2], done_pulse[2], cnt_of(2));
        end
        step();
        tests++;
        if (done_pulse[2] !== 1'b0 || done[2] !== 1'b1) begin
            fails++;
            $display("FAIL zero_limit_once: pulse=%b done=%b want 0/1", done_pulse[2], done[2]);
        end
    endtask

    task automatic test_frame_hold();
        int c0, prev, changes, at;
        set_lim(3, 1000); start[3] = 1'b1;
        step();
        steps(4);
        c0 = cnt_of(3); prev = c0; changes = 0; at = -1;
        new_frame = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (cnt_of(3) != prev) begin
                changes++; at = i; prev = cnt_of(3);
            end
        end
        new_frame = 1'b0;
        steps(4);
        tests++;
        if (changes != 1 || at != S + 1 || cnt_of(3) != c0 + 1) begin
            fails++;
            $display("FAIL frame_hold: changes=%0d at=%0d count=%0d want 1/%0d/%0d",
                     changes, at, cnt_of(3), S + 1, c0 + 1);
        end
    endtask

    task automatic test_reset_midrun();
        set_lim(0, 50); loop_mode[0] = 1'b0; start[0] = 1'b1;
        step();
        for (int k = 0; k < 7; k++) frame();
        tests++;
        if (cnt_of(0) != 7) begin
            fails++;
            $display("FAIL midrun_pre: count=%0d want 7", cnt_of(0));
        end
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        tests++;
        if (count !== '0 || running !== '0 || done !== '0 || done_pulse !== '0) begin
            fails++;
            $display("FAIL midrun_reset: count=%h run=%b done=%b pulse=%b want 0",
                     count, running, done, done_pulse);
        end
        steps(2);
        reset = 1'b1;
        step();
        tests++;
        if (count !== '0 || running !== '0 || done_pulse !== '0) begin
            fails++;
            $display("FAIL midrun_after: count=%h run=%b pulse=%b want 0",
                     count, running, done_pulse);
        end
    endtask

    task automatic test_reset_nf_high();
        reset = 1'b0; new_frame = 1'b1;
        steps(3);
        reset = 1'b1;
        set_lim(0, 50); start[0] = 1'b1;
        step();
        steps(10);
        tests++;
        if (cnt_of(0) != 0) begin
            fails++;
            $display("FAIL nf_high_release: count=%0d want 0", cnt_of(0));
        end
        new_frame = 1'b0;
        steps(4);
        frame();
        tests++;
        if (cnt_of(0) != 1) begin
            fails++;
            $display("FAIL nf_after_fall: count=%0d want 1", cnt_of(0));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < N; c++) begin
                start[c] = ($urandom_range(0, 15) == 0);
                stop[c] = ($urandom_range(0, 40) == 0);
                if ($urandom_range(0, 9) == 0) pause[c] = ~pause[c];
                loop_mode[c] = $urandom_range(0, 1);
                set_lim(c, $urandom_range(0, 5));
            end
            if ($urandom_range(0, 2) == 0) new_frame = ~new_frame;
            step();
            tests++;
            if (count !== exp_count() || running !== exp_bits(0)
                || done !== exp_bits(1) || done_pulse !== exp_bits(2)) begin
                fails++;
                if (fails < 20)
                    $display("FAIL random_cyc%0d: count=%h run=%b done=%b pulse=%b want %h/%b/%b/%b",
                             i, count, running, done, done_pulse,
                             exp_count(), exp_bits(0), exp_bits(1), exp_bits(2));
            end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_loop();
        test_pause();
        test_start_stop_zero();
        test_frame_hold();
        test_reset_midrun();
        test_reset_nf_high();
        pause = '0;
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
